// File: rtl/pc_control.sv
// Instruction-fetch PC generator: issues word-aligned fetch addresses on an
// AXI-style read-address channel, with redirect and buffer-free throttling.
//
// state  | meaning
// S_IDLE | no request outstanding; arvalid=0
// S_REQ  | request presented; arvalid=1, araddr held until arready
module pc_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        buffer_free,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t      state;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] jump_tgt;
  logic        jump_addr_unused;

  assign jump_tgt         = {jump_addr[31:2], 2'b00};
  assign jump_addr_unused = ^jump_addr[1:0];

  // rst_n is active-high: the name is inherited from the surrounding front end.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= S_IDLE;
      arvalid   <= 1'b0;
      araddr    <= {RESET_PC[31:2], 2'b00};
      pend      <= 1'b0;
      pend_addr <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (jump) araddr <= jump_tgt;
          pend    <= 1'b0;
          arvalid <= buffer_free;
          state   <= buffer_free ? S_REQ : S_IDLE;
        end
        S_REQ: begin
          if (arready) begin
            // A fresh jump beats a pending one, which beats the sequential step.
            if (jump)      araddr <= jump_tgt;
            else if (pend) araddr <= pend_addr;
            else           araddr <= araddr + PC_STEP;
            pend    <= 1'b0;
            arvalid <= buffer_free;
            state   <= buffer_free ? S_REQ : S_IDLE;
          end else if (jump) begin
            // Address must stay stable while stalled; remember the redirect.
            pend      <= 1'b1;
            pend_addr <= jump_tgt;
          end
        end
        default: begin
          state   <= S_IDLE;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the fetch channel.
module tb_pc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump;
  logic [31:0] jump_addr;
  logic        buffer_free;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_valid;
  longint      m_addr;
  longint      pend_q[$];

  pc_control #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .jump(jump), .jump_addr(jump_addr),
    .buffer_free(buffer_free), .arvalid(arvalid), .araddr(araddr),
    .arready(arready)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    longint tgt;
    tgt = longint'(jump_addr) - longint'(jump_addr % 4);
    if (rst_n) begin
      m_valid = 1'b0;
      m_addr  = 0;
      pend_q.delete();
    end else if (!m_valid) begin
      if (jump) m_addr = tgt;
      pend_q.delete();
      m_valid = buffer_free;
    end else if (arready) begin
      if (jump)                   m_addr = tgt;
      else if (pend_q.size() > 0) m_addr = pend_q[$];
      else                        m_addr = (m_addr + 4) % (64'd1 << 32);
      pend_q.delete();
      m_valid = buffer_free;
    end else if (jump) begin
      pend_q.push_back(tgt);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input bit r, input bit j, input logic [31:0] ja,
                     input bit bf, input bit ar);
    rst_n = r; jump = j; jump_addr = ja; buffer_free = bf; arready = ar;
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_arvalid"}, {31'h0, arvalid}, {31'h0, m_valid});
    chk({tag, "_araddr"}, araddr, m_addr[31:0]);
  endtask

  initial begin
    m_valid = 1'b0; m_addr = 0;
    rst_n = 1'b1; jump = 1'b0; jump_addr = 32'h0; buffer_free = 1'b1; arready = 1'b1;

    // 1: reset then streaming from RESET_PC
    cyc("rst0", 1, 0, 0, 1, 1);
    cyc("rst1", 1, 0, 0, 1, 1);
    chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    cyc("first", 0, 0, 0, 1, 1);
    chk("first_arvalid", {31'h0, arvalid}, 32'h1);
    chk("first_araddr", araddr, 32'h0);
    for (int i = 0; i < 4; i++) cyc("stream", 0, 0, 0, 1, 1);
    chk("stream_0x10", araddr, 32'h10);

    // 2: stall at 0x10
    for (int i = 0; i < 3; i++) cyc("stall", 0, 0, 0, 1, 0);
    chk("stall_hold", araddr, 32'h10);
    cyc("stall_rel", 0, 0, 0, 1, 1);
    chk("stall_next", araddr, 32'h14);

    // 3: throttling
    cyc("bf_drop", 0, 0, 0, 0, 1);
    chk("bf_drop_valid", {31'h0, arvalid}, 32'h0);
    cyc("bf_idle0", 0, 0, 0, 0, 1);
    cyc("bf_idle1", 0, 0, 0, 0, 1);
    chk("bf_idle_valid", {31'h0, arvalid}, 32'h0);
    cyc("bf_up", 0, 0, 0, 1, 0);
    cyc("bf_stall0", 0, 0, 0, 0, 0);
    cyc("bf_stall1", 0, 0, 0, 0, 0);
    chk("bf_persist", {31'h0, arvalid}, 32'h1);
    chk("bf_persist_addr", araddr, 32'h18);
    cyc("bf_hs", 0, 0, 0, 1, 1);
    cyc("to_0x20", 0, 0, 0, 1, 1);
    chk("at_0x20", araddr, 32'h20);

    // 4: jump during handshake, unaligned target
    cyc("jump_hs", 0, 1, 32'h1003, 1, 1);
    chk("jump_hs_addr", araddr, 32'h1000);

    // 5: jump during a stall
    cyc("to_0x40", 0, 1, 32'h40, 1, 1);
    cyc("jstall0", 0, 1, 32'h200, 1, 0);
    chk("jstall_hold", araddr, 32'h40);
    cyc("jstall1", 0, 0, 0, 1, 0);
    cyc("jstall_hs", 0, 0, 0, 1, 1);
    chk("jstall_target", araddr, 32'h200);
    cyc("jstall_next", 0, 0, 0, 1, 1);
    chk("jstall_seq", araddr, 32'h204);

    // 6: wraparound and reset mid-stall
    cyc("to_top", 0, 1, 32'hFFFF_FFFC, 1, 1);
    cyc("wrap", 0, 0, 0, 1, 1);
    chk("wrap_addr", araddr, 32'h0);
    cyc("pre_rst", 0, 0, 0, 1, 1);
    cyc("mid_stall", 0, 1, 32'h880, 1, 0);
    cyc("mid_rst", 1, 0, 0, 1, 0);
    chk("mid_rst_valid", {31'h0, arvalid}, 32'h0);
    chk("mid_rst_addr", araddr, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, j, bf, ar;
      logic [31:0] ja;
      r  = ($urandom_range(0, 99) < 2);
      j  = ($urandom_range(0, 7) == 0);
      bf = ($urandom_range(0, 3) != 0);
      ar = ($urandom_range(0, 1) == 1);
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      cyc("rand", r, j, ja, bf, ar);
      chk("rand_align", {30'h0, araddr[1:0]}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
